// File: rtl/ifetch_stage.sv
// Instruction fetch stage: holds the PC, issues one outstanding fetch at a
// time over a valid/ready handshake, and presents the returned word to decode.
// Redirects from execute override the PC and squash any stale in-flight fetch.
module ifetch_stage #(
    parameter int                 ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              resetl,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [10:0]       opcode,
    output logic [ADDR_W-1:0] pc_out
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
    logic [31:0]         instr_q, instr_d;
    logic                kill_q, kill_d;
    // Holds off the first request until one clock edge after reset release.
    logic                started_q, started_d;

    logic [ADDR_W-1:0]   tgt;
    logic                req_fire;

    assign tgt            = redirect_target & ALIGN_MASK;
    assign imem_req_valid = started_q && (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign instr_valid    = (state_q == S_HOLD);
    assign instr          = instr_q;
    assign opcode         = instr_q[31:21];
    assign pc_out         = pc_out_q;

    // Next-state logic; redirect takes priority over every other event.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_out_d  = pc_out_q;
        instr_d   = instr_q;
        kill_d    = kill_q;
        started_d = 1'b1;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = tgt;
                    // Old-address request escaped this cycle: squash its response.
                    if (req_fire) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = tgt;
                    if (imem_rsp_valid) begin
                        // The only outstanding response is consumed right here.
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d  = imem_rsp_data;
                        pc_out_d = pc_q;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = tgt;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            pc_out_q  <= RESET_PC;
            instr_q   <= '0;
            kill_q    <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_out_q  <= pc_out_d;
            instr_q   <= instr_d;
            kill_q    <= kill_d;
            started_q <= started_d;
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: the bench plays instruction memory and the
// downstream consumer; expected {pc, word} pairs go into a scoreboard queue as
// responses are driven and are popped when the stage presents an instruction.
module tb_ifetch_stage;

    localparam int ADDR_W = 64;

    logic              CLK;
    logic              resetl;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [10:0]       opcode;
    logic [ADDR_W-1:0] pc_out;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] w;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ifetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
        .CLK             (CLK),
        .resetl          (resetl),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .opcode          (opcode),
        .pc_out          (pc_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait for a request, check its address, accept it.
    task automatic issue(input logic [63:0] exp_addr);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", imem_req_valid, 1);
        chk("req_addr", imem_addr, exp_addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("req_drop", imem_req_valid, 0);
    endtask

    // Return a word after lat cycles; keep=0 means the stage must discard it.
    task automatic respond(input logic [63:0] pc, input logic [31:0] w, input int lat, input bit keep);
        for (int i = 1; i < lat; i++) begin
            chk("wait_no_valid", instr_valid, 0);
            tick();
        end
        if (keep) sbq.push_back('{pc: pc, w: w});
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = w;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    // Wait for a presented instruction and compare it with the scoreboard head.
    task automatic present();
        exp_t e;
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk("instr_valid", instr_valid, 1);
        chk("sb_nonempty", (sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("instr", instr, e.w);
            chk("opcode", opcode, e.w[31:21]);
            chk("pc_out", pc_out, e.pc);
        end
    endtask

    // Stall hold cycles with ready low, then consume.
    task automatic consume(input int hold);
        logic [31:0] w0;
        logic [63:0] p0;
        w0 = instr;
        p0 = pc_out;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", instr_valid, 1);
            chk("hold_instr", instr, w0);
            chk("hold_pc", pc_out, p0);
            chk("hold_noreq", imem_req_valid, 0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("consumed", instr_valid, 0);
    endtask

    initial begin
        int n;
        resetl          = 1'b0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        instr_ready     = 1'b0;
        tick();
        tick();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc_out", pc_out, 0);

        // Reset release: first request only after the next edge.
        resetl = 1'b1;
        chk("rel_req_low", imem_req_valid, 0);
        tick();
        chk("rel_req_high", imem_req_valid, 1);
        imem_req_ready = 1'b1;
        chk("first_addr", imem_addr, 64'h0);
        tick();
        imem_req_ready = 1'b0;
        respond(64'h0, 32'h8B02_0020, 1, 1'b1);
        chk("first_valid_3cyc", instr_valid, 1);
        chk("first_opcode", opcode, 11'h458);
        present();
        consume(0);

        // Sequential fetches.
        for (int k = 1; k < 4; k++) begin
            issue(64'(4 * k));
            respond(64'(4 * k), 32'h1000_0000 + 32'(k * 32'h0111_1111), 1, 1'b1);
            present();
            consume(0);
        end

        // Stall in HOLD.
        issue(64'h10);
        respond(64'h10, 32'hABCD_1234, 2, 1'b1);
        present();
        consume(5);

        // Redirect while waiting; stale word must never appear.
        issue(64'h14);
        redirect_valid  = 1'b1;
        redirect_target = 64'h103;
        tick();
        redirect_valid  = 1'b0;
        chk("kill_wait_noreq", imem_req_valid, 0);
        respond(64'h14, 32'hF840_03E0, 1, 1'b0);
        chk("killed_not_shown", instr_valid, 0);
        issue(64'h100);
        respond(64'h100, 32'h9100_0421, 2, 1'b1);
        present();
        consume(0);

        // Redirect in HOLD with ready high: redirect wins over pc+4.
        issue(64'h104);
        respond(64'h104, 32'h1234_5678, 1, 1'b1);
        present();
        redirect_valid  = 1'b1;
        redirect_target = 64'h40;
        instr_ready     = 1'b1;
        tick();
        redirect_valid  = 1'b0;
        instr_ready     = 1'b0;
        chk("hold_redir_drop", instr_valid, 0);
        issue(64'h40);
        respond(64'h40, 32'hCAFE_0040, 3, 1'b1);
        present();
        consume(0);

        // Redirect coinciding with handshake, then a second redirect in WAIT.
        chk("req_before_redir", imem_addr, 64'h44);
        redirect_valid  = 1'b1;
        redirect_target = 64'h200;
        imem_req_ready  = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        redirect_target = 64'h302;
        tick();
        redirect_valid  = 1'b0;
        chk("b2b_wait", imem_req_valid, 0);
        respond(64'h44, 32'hDEAD_BEEF, 2, 1'b0);
        chk("b2b_killed", instr_valid, 0);
        issue(64'h300);
        respond(64'h300, 32'h0BAD_F00D, 1, 1'b1);
        present();
        consume(0);

        // Redirect in REQ without handshake, then PC wrap.
        redirect_valid  = 1'b1;
        redirect_target = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect_valid  = 1'b0;
        chk("redir_req_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        issue(64'hFFFF_FFFF_FFFF_FFFC);
        respond(64'hFFFF_FFFF_FFFF_FFFC, 32'h5555_AAAA, 1, 1'b1);
        present();
        consume(0);
        issue(64'h0);
        respond(64'h0, 32'h7777_0000, 1, 1'b1);
        present();
        consume(1);

        // Asynchronous reset in the middle of WAIT.
        issue(64'h4);
        #1;
        resetl = 1'b0;
        #1;
        chk("amid_req_valid", imem_req_valid, 0);
        chk("amid_instr_valid", instr_valid, 0);
        chk("amid_instr", instr, 0);
        chk("amid_pc_out", pc_out, 0);
        tick();
        resetl = 1'b1;
        // Stray response while in REQ must be ignored.
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hFFFF_0000;
        tick();
        imem_rsp_valid = 1'b0;
        chk("stray_ignored", instr_valid, 0);
        issue(64'h0);
        respond(64'h0, 32'h8B02_0020, 1, 1'b1);
        present();
        consume(0);

        n = sbq.size();
        chk("sb_drained", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
